// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin I/D line-fill and write-back arbiter onto a single-port line memory,
// with a park cycle between transactions so stale rvalid/wdone can never satisfy the next request.
module mem_arbiter #(
  parameter int ARCH_BITS = 32,
  parameter int LINE_BITS = 128,
  parameter int PARK_BIT  = 31
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_req,
  input  logic [ARCH_BITS-1:0] i_addr,
  output logic                 i_done,
  output logic [LINE_BITS-1:0] i_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [ARCH_BITS-1:0] d_addr,
  input  logic [LINE_BITS-1:0] d_wdata,
  output logic                 d_done,
  output logic [LINE_BITS-1:0] d_rdata,
  output logic [ARCH_BITS-1:0] mem_raddr,
  output logic [ARCH_BITS-1:0] mem_waddr,
  output logic [LINE_BITS-1:0] mem_wdata,
  output logic                 mem_we,
  input  logic [LINE_BITS-1:0] mem_rdata,
  input  logic                 mem_rvalid,
  input  logic                 mem_wdone
);
  localparam logic [ARCH_BITS-1:0] PARK_MASK = {{(ARCH_BITS-1){1'b0}}, 1'b1} << PARK_BIT;
  localparam logic [ARCH_BITS-1:0] LINE_MASK = ~{{(ARCH_BITS-4){1'b0}}, 4'hf};
  typedef enum logic [1:0] {IDLE, READ, WRITE, PARK} state_t;
  state_t r_state, w_next;
  logic r_gnt_d, r_last_d, w_pick_d, w_write;
  logic [ARCH_BITS-1:0] r_addr, w_addr;
  // D wins unless I is also pending and D had the previous grant
  assign w_pick_d = d_req & (~i_req | ~r_last_d);
  assign w_write  = w_pick_d & d_we;
  assign w_addr   = (w_pick_d ? d_addr : i_addr) & LINE_MASK;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = !(i_req || d_req) ? IDLE : w_write ? WRITE : READ;
      READ:    w_next = mem_rvalid ? PARK : READ;
      WRITE:   w_next = mem_wdone ? PARK : WRITE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_gnt_d   <= 1'b0;
      r_last_d  <= 1'b0;
      r_addr    <= '0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      mem_raddr <= PARK_MASK;
      mem_waddr <= PARK_MASK;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
    end else begin
      r_state <= w_next;
      i_done  <= 1'b0;
      d_done  <= 1'b0;
      case (r_state)
        IDLE: if (i_req || d_req) begin
          r_gnt_d  <= w_pick_d;
          r_last_d <= w_pick_d;
          r_addr   <= w_addr;
          if (w_write) begin
            mem_waddr <= w_addr;
            mem_wdata <= d_wdata;
            mem_we    <= 1'b1;
          end else mem_raddr <= w_addr;
        end
        READ: if (mem_rvalid) begin
          if (r_gnt_d) d_rdata <= mem_rdata;
          else i_rdata <= mem_rdata;
          d_done <= r_gnt_d;
          i_done <= !r_gnt_d;
        end
        WRITE: if (mem_wdone) begin
          mem_we <= 1'b0;
          d_done <= 1'b1;
        end
        PARK: begin
          mem_raddr <= r_addr ^ PARK_MASK;
          mem_we    <= 1'b0;
        end
      endcase
    end
  end
  a_hold: assert property (@(posedge clk) disable iff (rst)
    (r_state == READ || r_state == WRITE) |-> (r_gnt_d ? d_req : i_req))
    else $error("mem_arbiter: client dropped req mid-transaction");
  a_park: assert property (@(posedge clk) disable iff (rst)
    !(i_req && i_addr[PARK_BIT]) && !(d_req && d_addr[PARK_BIT]))
    else $error("mem_arbiter: request address has the park bit set");
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter against a line memory model
// with read delay 7 and write delay 5 that restarts its counters on address / WE change.
module tb_mem_arbiter;
  localparam logic [31:0] PARK = 32'h8000_0000;
  localparam logic [127:0] DEAD = {8{16'hDEAD}};
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic i_req, d_req, d_we, i_done, d_done, mem_we;
  logic [31:0] i_addr, d_addr, mem_raddr, mem_waddr;
  logic [127:0] d_wdata, i_rdata, d_rdata, mem_wdata;
  logic [127:0] m_rdata = '0;
  logic [127:0] mem [0:255];
  logic [31:0] m_rprev = PARK, m_wprev = PARK;
  logic m_rvalid_q = 1'b0, m_wdone_q = 1'b0, m_weprev = 1'b0, m_ready = 1'b0;
  logic force_rv = 1'b0, force_wd = 1'b0;
  logic m_rv, m_wd;
  int m_rcnt = 0, m_wcnt = 0, cyc = 0, n_chk = 0, n_fail = 0, t_issue = 0;
  typedef struct packed {logic wr; logic d; logic [127:0] data;} exp_t;
  exp_t sb[$];

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(m_rdata), .mem_rvalid(m_rv), .mem_wdone(m_wd)
  );

  function automatic logic [127:0] line_of(int idx);
    return idx == 4 ? {16{8'hA5}} : {4{32'hC0DE_0000 | idx}};
  endfunction

  // Memory outputs are only believed while the address they were produced for is still presented
  assign m_rv = (m_rvalid_q && mem_raddr == m_rprev) || force_rv;
  assign m_wd = (m_wdone_q && mem_we && mem_waddr == m_wprev) || force_wd;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!m_ready) begin
      for (int k = 0; k < 256; k++) mem[k] <= line_of(k);
      m_ready <= 1'b1;
    end
    if (mem_raddr != m_rprev) begin
      m_rprev <= mem_raddr; m_rcnt <= 0; m_rvalid_q <= 1'b0;
    end else if (m_rcnt == 7) begin
      m_rvalid_q <= 1'b1; m_rdata <= mem[mem_raddr[11:4]];
    end else m_rcnt <= m_rcnt + 1;
    if (!mem_we || !m_weprev || mem_waddr != m_wprev) begin
      m_wprev <= mem_waddr; m_weprev <= mem_we; m_wcnt <= 0; m_wdone_q <= 1'b0;
    end else if (m_wcnt == 5) begin
      if (!m_wdone_q) mem[mem_waddr[11:4]] <= mem_wdata;
      m_wdone_q <= 1'b1;
    end else m_wcnt <= m_wcnt + 1;
  end

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(logic d, logic we, logic [31:0] a, logic [127:0] wd, logic [127:0] exp);
    @(negedge clk);
    if (d) begin d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; end
    else begin i_req = 1'b1; i_addr = a; end
    sb.push_back('{we, d, exp});
    t_issue = cyc;
  endtask

  task automatic wait_done(string tag, int lat);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (!(i_done || d_done) && n < 300) begin @(negedge clk); n++; end
    chk($sformatf("%s_seen", tag), 128'(i_done || d_done), 128'(1));
    if (!(i_done || d_done)) begin
      i_req = 1'b0; d_req = 1'b0;
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    chk($sformatf("%s_client", tag), 128'(d_done), 128'(e.d));
    chk($sformatf("%s_single", tag), 128'(i_done & d_done), 128'(0));
    if (!e.wr) chk($sformatf("%s_data", tag), d_done ? d_rdata : i_rdata, e.data);
    if (lat >= 0) chk($sformatf("%s_lat", tag), 128'(cyc - t_issue), 128'(lat));
    if (d_done) d_req = 1'b0; else i_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "tb_mem_arbiter timeout");
  end

  initial begin
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_i_done", 128'(i_done), 128'(0));
    chk("rst_d_done", 128'(d_done), 128'(0));
    chk("rst_we", 128'(mem_we), 128'(0));
    chk("rst_raddr", 128'(mem_raddr), 128'(PARK));
    chk("rst_waddr", 128'(mem_waddr), 128'(PARK));
    chk("rst_wdata", mem_wdata, 128'(0));
    chk("rst_i_rdata", i_rdata, 128'(0));
    chk("rst_d_rdata", d_rdata, 128'(0));
    rst = 1'b0;
    // single I fill
    issue(1'b0, 1'b0, 32'h40, '0, line_of(4));
    wait_done("t1", 11);
    // write-back, then read it back
    issue(1'b1, 1'b1, 32'h100, DEAD, '0);
    repeat (3) @(negedge clk);
    chk("t2_we", 128'(mem_we), 128'(1));
    chk("t2_waddr", 128'(mem_waddr), 128'(32'h100));
    chk("t2_wdata", mem_wdata, DEAD);
    wait_done("t2w", 9);
    chk("t2_we_drop", 128'(mem_we), 128'(0));
    issue(1'b1, 1'b0, 32'h100, '0, DEAD);
    wait_done("t2r", 11);
    // contention from reset: D first, then alternation gives I before the re-raised D
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk); rst = 1'b0;
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h200; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    sb.push_back('{1'b0, 1'b1, line_of('h30)});
    sb.push_back('{1'b0, 1'b0, line_of('h20)});
    wait_done("t3_first", -1);
    @(negedge clk); d_req = 1'b1; d_addr = 32'h310;
    sb.push_back('{1'b0, 1'b1, line_of('h31)});
    wait_done("t3_alt", -1);
    wait_done("t3_last", -1);
    // back-to-back reads of the same line
    issue(1'b0, 1'b0, 32'h400, '0, line_of('h40));
    wait_done("t4a", 11);
    @(negedge clk);
    chk("t4_park", 128'(mem_raddr), 128'(32'h8000_0400));
    i_req = 1'b1; i_addr = 32'h400;
    sb.push_back('{1'b0, 1'b0, line_of('h40)});
    t_issue = cyc;
    wait_done("t4b", 11);
    // reset in the middle of a read
    issue(1'b0, 1'b0, 32'h500, '0, line_of('h50));
    repeat (5) @(negedge clk);
    rst = 1'b1; i_req = 1'b0;
    @(negedge clk);
    chk("t5_i_done", 128'(i_done), 128'(0));
    chk("t5_raddr", 128'(mem_raddr), 128'(PARK));
    chk("t5_we", 128'(mem_we), 128'(0));
    void'(sb.pop_front());
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("t5_quiet", 128'(i_done), 128'(0));
    issue(1'b0, 1'b0, 32'h500, '0, line_of('h50));
    wait_done("t5r", 11);
    // spurious rvalid / wdone while idle
    @(negedge clk); force_rv = 1'b1; force_wd = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("t6_i_done%0d", k), 128'(i_done), 128'(0));
      chk($sformatf("t6_d_done%0d", k), 128'(d_done), 128'(0));
      chk($sformatf("t6_raddr%0d", k), 128'(mem_raddr), 128'(32'h8000_0500));
    end
    force_rv = 1'b0; force_wd = 1'b0;
    issue(1'b0, 1'b0, 32'h40, '0, line_of(4));
    wait_done("t6r", 11);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
